uart_tx_fifo: RTL and testbench

- Byte FIFO plus transmit sequencer placed directly upstream of the UART RS232 transmitter.
- User logic pushes bytes at any rate while space is available.
- The sequencer pops one byte at a time, presents it on TxData, pulses TxEn for one cycle, and waits for TxDone before starting the next byte.
- Replaces the permanently-high TxEn tie-off in the UART top level.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and sequencer state encoding for the UART transmit FIFO.
package uart_pkg;
  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } seq_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO; Full/Empty/Count come only from registered occupancy.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus one-byte-in-flight transmit sequencer feeding the UART transmitter.
// UART_TX_GAP_EN adds a GAP state holding off GAP_CYCLES cycles after each TxDone.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 4
`ifdef UART_TX_GAP_EN
  ,
  parameter int GAP_CYCLES = 16
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BYTE_W-1:0] WrData,
  input  logic              WrEn,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  input  logic              OvfClr,
  output logic [BYTE_W-1:0] TxData,
  output logic              TxEn,
  input  logic              TxDone,
  output logic              TxBusy,
  output seq_state_e        DbgState
);
  seq_state_e        state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              ovf_q, ovf_d;
  logic              pop;
  logic [BYTE_W-1:0] rd_data;

`ifdef UART_TX_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

  sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk     (Clk),
    .rst     (Rst),
    .push    (WrEn),
    .wr_data (WrData),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (Full),
    .empty   (Empty),
    .count   (Count)
  );

  // A push attempted while Full is lost even if a pop frees space this edge.
  always_comb begin
    ovf_d = ovf_q;
    if (WrEn && Full) ovf_d = 1'b1;
    else if (OvfClr)  ovf_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!Empty) begin
          pop       = 1'b1;
          tx_data_d = rd_data;
          tx_en_d   = 1'b1;
          state_d   = START;
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (TxDone) begin
`ifdef UART_TX_GAP_EN
          state_d   = GAP;
          gap_cnt_d = '0;
`else
          state_d   = IDLE;
`endif
        end
      end
`ifdef UART_TX_GAP_EN
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef UART_TX_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ovf_q     <= ovf_d;
`ifdef UART_TX_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign TxData   = tx_data_q;
  assign TxEn     = tx_en_q;
  assign Overflow = ovf_q;
  assign TxBusy   = (state_q != IDLE);
  assign DbgState = state_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner sequences, and random
// traffic checked against a queue/timeline reference model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_TX_GAP_EN
  localparam int GAP = 16;
`else
  localparam int GAP = 0;
`endif

  // Clock / reset and DUT signals
  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic [7:0]        WrData = '0;
  logic              WrEn = 1'b0;
  logic              OvfClr = 1'b0;
  logic              TxDone = 1'b0;
  logic              Full, Empty, Overflow, TxEn, TxBusy;
  logic [ADDR_W:0]   Count;
  logic [7:0]        TxData;
  seq_state_e        DbgState;

  always #5 Clk = ~Clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .WrData   (WrData),
    .WrEn     (WrEn),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow),
    .OvfClr   (OvfClr),
    .TxData   (TxData),
    .TxEn     (TxEn),
    .TxDone   (TxDone),
    .TxBusy   (TxBusy),
    .DbgState (DbgState)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: byte queue plus a timeline of when the sequencer may pop next.
  logic [7:0] exp_q[$];
  int         cyc        = 0;
  int         m_ready_at = 0;
  int         m_pop_edge = 0;
  int         m_done_edge = 0;
  bit         m_inflight = 0;
  bit         m_txen     = 0;
  bit         m_busy     = 0;
  bit         m_ovf      = 0;
  logic [7:0] m_txdata   = '0;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         done;
    bit         clr;
    int         e_count;
    bit         e_en;
    logic [7:0] e_data;
    bit         e_busy;
    bit         e_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_inflight = 0;
    m_ready_at = 0;
    m_txen     = 0;
    m_busy     = 0;
    m_ovf      = 0;
    m_txdata   = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare all outputs.
  task automatic step(input bit wr, input logic [7:0] d, input bit done, input bit clr);
    bit full_pre, do_pop, fin;
    WrEn   = wr;
    WrData = d;
    TxDone = done;
    OvfClr = clr;
    full_pre = (exp_q.size() == DEPTH);
    do_pop   = !m_inflight && (cyc >= m_ready_at) && (exp_q.size() != 0);
    fin      = m_inflight && done && (cyc >= m_pop_edge + 2);
    m_txen   = do_pop;
    if (do_pop) begin
      m_txdata   = exp_q.pop_front();
      m_inflight = 1;
      m_pop_edge = cyc;
    end
    if (fin) begin
      m_inflight = 0;
      m_ready_at = cyc + 1 + GAP;
    end
    if (wr && !full_pre) exp_q.push_back(d);
    if (wr && full_pre) m_ovf = 1;
    else if (clr)       m_ovf = 0;
    m_busy = m_inflight || (cyc < m_ready_at - 1);
    @(posedge Clk);
    #1;
    check("count",    Count,    exp_q.size());
    check("full",     Full,     exp_q.size() == DEPTH);
    check("empty",    Empty,    exp_q.size() == 0);
    check("tx_en",    TxEn,     m_txen);
    check("tx_data",  TxData,   m_txdata);
    check("tx_busy",  TxBusy,   m_busy);
    check("overflow", Overflow, m_ovf);
    cyc++;
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    WrEn = 0; WrData = '0; TxDone = 0; OvfClr = 0;
    #2;
    Rst = 1'b1;
    #1;
    check("rst_count",    Count,    0);
    check("rst_empty",    Empty,    1);
    check("rst_full",     Full,     0);
    check("rst_overflow", Overflow, 0);
    check("rst_tx_data",  TxData,   0);
    check("rst_tx_en",    TxEn,     0);
    check("rst_tx_busy",  TxBusy,   0);
    check("rst_state",    DbgState, IDLE);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    cyc++;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int pulses;
    logic [7:0] seen[4];
    int wr_pct;
    bit done;

    // TxDone in IDLE and in START is ignored; Overflow clear with nothing set.
    vecs[0] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0};
    vecs[1] = '{1, 8'hA5, 0, 0, 1, 0, 8'h00, 0, 0};
    vecs[2] = '{0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0};
    vecs[3] = '{0, 8'h00, 1, 0, 0, 0, 8'hA5, 1, 0};
    vecs[4] = '{0, 8'h00, 0, 0, 0, 0, 8'hA5, 1, 0};
    vecs[5] = '{1, 8'h3C, 0, 0, 1, 0, 8'hA5, 1, 0};
    vecs[6] = '{1, 8'hC3, 0, 1, 2, 0, 8'hA5, 1, 0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].wr, vecs[i].d, vecs[i].done, vecs[i].clr);
      check("vec_count",    Count,    vecs[i].e_count);
      check("vec_tx_en",    TxEn,     vecs[i].e_en);
      check("vec_tx_data",  TxData,   vecs[i].e_data);
      check("vec_busy",     TxBusy,   vecs[i].e_busy);
      check("vec_overflow", Overflow, vecs[i].e_ovf);
    end

    // Single byte: TxEn one cycle, two edges after the push; idle and empty after TxDone.
    do_reset();
    step(1, 8'hA5, 0, 0);
    check("a5_no_early_en", TxEn, 0);
    step(0, 8'h00, 0, 0);
    check("a5_tx_en", TxEn, 1);
    check("a5_tx_data", TxData, 8'hA5);
    step(0, 8'h00, 0, 0);
    check("a5_one_pulse", TxEn, 0);
    repeat (3) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    repeat (GAP) step(0, 8'h00, 0, 0);
    check("a5_busy_after_done", TxBusy, 0);
    check("a5_empty_after_done", Empty, 1);

    // Four bytes, transmitter answering 10 cycles after each TxEn.
    do_reset();
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1, 8'(i), 0, 0);
      if (TxEn) begin
        if (pulses < 4) seen[pulses] = TxData;
        pulses++;
      end
    end
    for (int c = 0; c < 150; c++) begin
      step(0, 8'h00, m_inflight && (cyc == m_pop_edge + 10), 0);
      if (TxEn) begin
        if (pulses < 4) seen[pulses] = TxData;
        pulses++;
      end
    end
    check("seq4_pulses", pulses, 4);
    for (int i = 0; i < 4; i++) check("seq4_order", seen[i], 8'(i + 1));
    check("seq4_count", Count, 0);

    // DEPTH+2 pushes with TxDone withheld.
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) step(1, 8'h40 + 8'(i), 0, 0);
    check("fill_full", Full, 1);
    check("fill_count", Count, DEPTH);
    check("fill_overflow", Overflow, 1);
    step(0, 8'h00, 0, 1);
    check("ovf_clear", Overflow, 0);

    // Push while Full in the same edge as a TxDone-driven pop.
    step(0, 8'h00, 1, 0);
    repeat (GAP) step(0, 8'h00, 0, 0);
    step(1, 8'hEE, 0, 0);
    check("fullpop_tx_en", TxEn, 1);
    check("fullpop_tx_data", TxData, 8'h41);
    check("fullpop_overflow", Overflow, 1);
    check("fullpop_count", Count, DEPTH - 1);

    // Reset in WAIT_DONE with five bytes queued.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 8'h50 + 8'(i), 0, 0);
    check("midframe_count", Count, 5);
    check("midframe_state", DbgState, WAIT_DONE);
    do_reset();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step(0, 8'h00, ($urandom_range(0, 3) == 0), 0);
      if (TxEn) pulses++;
    end
    check("post_reset_no_tx", pulses, 0);

    // Random traffic against the model.
    do_reset();
    wr_pct = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) wr_pct = $urandom_range(10, 90);
      done = 0;
      if (m_inflight && cyc == m_done_edge) done = 1;
      else if (!m_inflight && cyc >= m_ready_at && $urandom_range(0, 7) == 0) done = 1;
      else if (m_inflight && cyc == m_pop_edge + 1 && $urandom_range(0, 3) == 0) done = 1;
      step(($urandom_range(1, 100) <= wr_pct), 8'($urandom), done,
           ($urandom_range(0, 15) == 0));
      if (m_txen) m_done_edge = m_pop_edge + $urandom_range(2, 12);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
